// File: rtl/seg_scan_digit_driver_if.sv
// seg_scan_digit_driver_if: valid/ready write channel carrying a 3-digit BCD value
//   wr_data[11:8] digit on a1, [7:4] on a2, [3:0] on a3; transfer when wr_valid && wr_ready at a rising edge
interface seg_scan_digit_driver_if;
  logic [11:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  modport master(output wr_data, wr_valid, input wr_ready);
  modport slave(input wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/seg_scan_digit_driver.sv
// seg_scan_digit_driver: drives the shared 7-segment bus with the digit of the active anode, frame-synchronous updates
//   clk, rst_n (async, active-low); a1/a2/a3 one-hot anode strobes; wr write channel (slave);
//   seg[6:0] = g..a segments; blank high while segments forced off; scan_err sticky non-one-hot anode flag
module seg_scan_digit_driver #(
  parameter int BLANK_CYCLES   = 2700,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a1,
  input  logic                    a2,
  input  logic                    a3,
  seg_scan_digit_driver_if.slave  wr,
  output logic [6:0]              seg,
  output logic                    blank,
  output logic                    scan_err
);
  localparam int CW = BLANK_CYCLES > 0 ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BLANK_CYCLES);
  logic [2:0]    anode_n, anode_q;
  logic [11:0]   shadow, disp;
  logic          pending, boundary;
  logic [CW-1:0] cnt;
  logic [3:0]    nib;
  logic [6:0]    dec;
  assign anode_n     = {a1, a2, a3};
  // Only a clean 001 -> 100 step counts as a frame boundary; corrupted sequences never commit
  assign boundary    = anode_q == 3'b001 && anode_n == 3'b100;
  assign wr.wr_ready = !pending;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q  <= 3'b100;
      shadow   <= '0;
      pending  <= 1'b0;
      disp     <= '0;
      cnt      <= CNT_INIT;
      scan_err <= 1'b0;
    end else begin
      anode_q <= anode_n;
      cnt     <= anode_n != anode_q ? CNT_INIT : cnt - CW'(cnt != '0);
      if (!$onehot(anode_n)) scan_err <= 1'b1;
      // Commit and accept are exclusive: accept needs pending=0, commit needs pending=1
      if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end else if (wr.wr_valid && !pending) begin
        shadow  <= wr.wr_data;
        pending <= 1'b1;
      end
    end
  end
  always_comb begin
    nib = anode_q[2] ? disp[11:8] : anode_q[1] ? disp[7:4] : disp[3:0];
    case (nib)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
    blank = cnt != '0 || !$onehot(anode_q);
    seg   = (blank ? 7'b0000000 : dec) ^ {7{SEG_ACTIVE_LOW}};
  end
endmodule

// File: tb/tb_seg_scan_digit_driver.sv
// tb_seg_scan_digit_driver: randomized scoreboard bench against a behavioural display model
module tb_seg_scan_digit_driver;
  localparam int BLANK = 4;
  localparam logic [6:0] TBL [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                      7'h7f, 7'h6f, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  typedef struct packed {
    logic [6:0] seg;
    logic       blank;
    logic       ready;
    logic       err;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a1 = 1'b1, a2 = 1'b0, a3 = 1'b0;
  logic [6:0] seg;
  logic       blank, scan_err;
  exp_t       q[$];
  int         checks = 0, errors = 0, sc = 0;
  logic [2:0]  m_an;
  logic [11:0] m_sh, m_disp;
  bit          m_pend, m_err, m_acc;
  int          m_since;
  seg_scan_digit_driver_if wif();
  seg_scan_digit_driver #(.BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .wr(wif.slave),
    .seg(seg), .blank(blank), .scan_err(scan_err)
  );
  always #5 clk = ~clk;
  function automatic int posn(logic [2:0] an);
    return an == 3'b100 ? 0 : an == 3'b010 ? 1 : an == 3'b001 ? 2 : -1;
  endfunction
  function automatic void m_reset();
    m_an = 3'b100; m_sh = '0; m_disp = '0; m_pend = 0; m_err = 0; m_since = 0; m_acc = 0;
  endfunction
  function automatic void m_step(logic [2:0] an, logic v, logic [11:0] d);
    m_acc = 0;
    if (m_an == 3'b001 && an == 3'b100 && m_pend) begin
      m_disp = m_sh; m_pend = 0;
    end else if (v && !m_pend) begin
      m_sh = d; m_pend = 1; m_acc = 1;
    end
    m_since = an != m_an ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
    if (posn(an) < 0) m_err = 1;
    m_an = an;
  endfunction
  function automatic exp_t m_out();
    exp_t e;
    int   p = posn(m_an);
    logic [3:0] dg = p < 0 ? 4'd0 : m_disp[4*(2-p) +: 4];
    e.blank = m_since < BLANK || p < 0;
    e.seg   = e.blank ? 7'd0 : TBL[dg];
    e.ready = !m_pend;
    e.err   = m_err;
    return e;
  endfunction
  task automatic chk(string n, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
    end
  endtask
  task automatic cyc(logic [2:0] an, logic v, logic [11:0] d);
    @(negedge clk); #1;
    rst_n = 1'b1; {a1, a2, a3} = an; wif.wr_valid = v; wif.wr_data = d;
    m_step(an, v, d);
    q.push_back(m_out());
  endtask
  task automatic scan(logic v, logic [11:0] d);
    cyc(3'b100 >> ((sc / 20) % 3), v, d);
    sc++;
  endtask
  task automatic run(int n);
    repeat (n) scan(1'b0, 12'h0);
  endtask
  task automatic do_reset(int n);
    repeat (n) begin
      @(negedge clk); #1;
      rst_n = 1'b0; {a1, a2, a3} = 3'b100; wif.wr_valid = 1'b0;
      m_reset();
      q.push_back(m_out());
    end
    sc = 0;
  endtask
  task automatic write_at(int p, logic [11:0] d);
    for (int k = 0; k < 100 && (sc / 20) % 3 != p; k++) scan(1'b0, 12'h0);
    scan(1'b1, d);
  endtask
  task automatic hold_write(logic [11:0] d);
    int k = 0;
    do begin scan(1'b1, d); k++; end while (!m_acc && k < 200);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seg", seg, e.seg);
        chk("blank", 7'(blank), 7'(e.blank));
        chk("wr_ready", 7'(wif.wr_ready), 7'(e.ready));
        chk("scan_err", 7'(scan_err), 7'(e.err));
      end
    end
  end
  initial begin
    wif.wr_valid = 1'b0; wif.wr_data = '0;
    m_reset();
    q.push_back(m_out());
    do_reset(2);
    run(40);
    write_at(1, 12'h123);
    hold_write(12'h456);
    run(80);
    write_at(0, 12'hA09);
    run(80);
    repeat (400) scan($urandom_range(0, 7) == 0, 12'($urandom));
    hold_write(12'h777);
    for (int k = 0; k < 100 && (sc / 20) % 3 != 2; k++) scan(1'b0, 12'h0);
    run(3);
    cyc(3'b110, 1'b0, 12'h0);
    sc = 0;
    run(80);
    hold_write(12'h888);
    for (int k = 0; k < 200 && !(sc % 20 == 1 && m_pend); k++) scan(1'b0, 12'h0);
    do_reset(2);
    run(100);
    @(negedge clk); #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard residue: got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_digit_driver.md
# seg_scan_digit_driver

Segment-side companion to the display anode scanner: consumes the one-hot anode strobes (a1, a2, a3) that the scanner rotates at 500 Hz from the 27 MHz clock and drives the shared 7-segment bus with the digit belonging to the active anode. A 3-digit BCD value is loaded over a valid/ready handshake into a shadow register and committed only at a frame boundary, so no partially updated frame is ever shown. A programmable blanking interval after every anode change suppresses ghosting.

## Interface

- BLANK_CYCLES, 2700, segments forced off for this many cycles after each anode change (100 µs at 27 MHz); 0 disables blanking.
- SEG_ACTIVE_LOW, 0, 1 inverts all seven bits of seg (common-anode panels).
- clk  input  1  system clock, 27 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- a1  input  1  anode strobe, digit 0 (most significant), synchronous to clk.
- a2  input  1  anode strobe, digit 1.
- a3  input  1  anode strobe, digit 2 (least significant).
- wr_data  input  12  BCD value: [11:8] digit for a1, [7:4] for a2, [3:0] for a3.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  shadow register free; transfer on wr_valid && wr_ready at a rising edge.
- seg  output  7  segments, seg[0]=a … seg[6]=g; active-high unless SEG_ACTIVE_LOW.
- blank  output  1  high while segments are forced off.
- scan_err  output  1  sticky: anode inputs were sampled non-one-hot.

## Operation

- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Registers: anode_q[2:0] = {a1,a2,a3} sampled each edge; shadow[11:0]; pending; disp[11:0]; blank counter cnt (width $clog2(BLANK_CYCLES+1)); scan_err.
- Reset values: anode_q=3'b100, shadow=0, pending=0, disp=0, cnt=BLANK_CYCLES, scan_err=0. Hence during and after reset: wr_ready=1, blank=1 (if BLANK_CYCLES>0), seg = all segments off.
- Handshake: wr_ready = !pending. Accept -> shadow<=wr_data, pending<=1. wr_data ignored when wr_ready=0.
- Frame boundary: edge where anode_q goes 3'b001 -> 3'b100. At that edge, if pending: disp<=shadow, pending<=0. A write is never accepted on that edge unless pending=0 beforehand; a write accepted on a boundary edge commits at the next boundary (no bypass).
- Anode change: any edge where the new sample differs from anode_q loads cnt<=BLANK_CYCLES; otherwise cnt decrements to 0 and saturates.
- blank = (cnt!=0) || !onehot(anode_q). seg = blank ? off : decode(disp nibble selected by anode_q).
- Decode (active-high, g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; 10–15 = dash 1000000.
- scan_err: set on any edge where the sampled value is not one-hot (including 000); cleared only by reset.
- Boundary detection uses only one-hot values; a corrupted sequence (e.g. 001 -> 110 -> 100) does not commit.

## Timing

- seg, blank, wr_ready are combinational from registers only; no input-to-output combinational paths.
- Anode input change at edge E sampled into anode_q at E; new digit is visible after BLANK_CYCLES further edges (E+BLANK_CYCLES); with BLANK_CYCLES=0 it is visible immediately after E.
- Write-to-display latency: from acceptance to the next 001->100 boundary, plus BLANK_CYCLES; max ~1 frame (3 scan periods) + BLANK_CYCLES.
- wr_ready reasserts one cycle after the boundary edge that clears pending.
- Reset assertion at any time (mid-blank, mid-pending) clears state immediately; pending write is discarded.

## Test plan

All with BLANK_CYCLES=4, SEG_ACTIVE_LOW=0, scanner model stepping 100->010->001 every 20 cycles.
- Reset: hold rst_n=0 -> seg=0000000, blank=1, wr_ready=1, scan_err=0; after release, blank drops 4 cycles later with seg=0111111 (digit 0 on a1).
- Write 12'h123 while a2 active -> wr_ready=0 next cycle; seg unchanged until 001->100; 4 cycles after boundary seg=0000110, then 1011011 on a2, 1001111 on a3; wr_ready=1 one cycle after boundary.
- Backpressure: second write 12'h456 while pending -> not accepted, display shows 123; hold wr_valid -> accepted after boundary, displayed one frame later.
- Non-BCD: write 12'hA09 -> a1 shows 1000000, a2 0111111, a3 1101111.
- Glitch: drive anodes 3'b110 for one cycle -> blank=1, seg=0000000, scan_err=1 and stays 1; no commit on that pseudo-boundary.
- Reset mid-blank with pending=1 -> outputs return to reset values immediately; previous shadow never displayed.
